hdec_decimator: RTL
===================

# hdec_decimator

Decimate-by-M output stage placed directly downstream of the 21-tap half-band-style FIR (20-bit signed output, DC gain 796) in the polyphase decimation chain. It discards the FIR's start-up transient and keeps one FIR sample in every M. Each kept sample is rescaled from the FIR accumulator width to the chain's sample width. Results are delivered through a 2-entry valid/ready output buffer, with sticky status flags for saturation and dropped samples.

## Interface
- DIN_W, 20, input sample width (FIR accumulator width)
- DOUT_W, 9, output sample width
- SHIFT, 9, right-shift applied to each kept sample (gain normalisation)
- M, 5, decimation factor (≥2)
- PHASE, 0, which sample of each group of M is kept (0..M-1)
- FLUSH_LEN, 21, number of valid input samples discarded after reset (FIR fill)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- din  in  DIN_W  signed FIR output sample
- din_valid  in  1  din carries a new sample this cycle (no backpressure to FIR)
- dout  out  DOUT_W  signed decimated sample
- dout_valid  out  1  dout holds a sample
- dout_ready  in  1  consumer accepts dout this cycle
- flag_clr  in  1  synchronous clear of sat_flag and drop_flag
- sat_flag  out  1  sticky: a kept sample was saturated
- drop_flag  out  1  sticky: a kept sample was lost because the buffer was full

## Operation
- Two states, FLUSH and RUN; reset enters FLUSH with flush count = 0 and phase = 0.
- FLUSH: each din_valid increments the flush count. No sample is kept. On the FLUSH_LEN-th valid sample, the block moves to RUN.
- RUN: each din_valid sample is tagged with the current phase. The phase then advances, wrapping M-1 → 0. A sample is kept when its phase equals PHASE.
- Cycles without din_valid change no counter.
- Scaling (macro on): compute r = (din + 2^(SHIFT-1)) >>> SHIFT in DIN_W+1 bits, i.e. round half up. Clamp r to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]. If clamping occurs, set sat_flag.
- Output buffer: 2-entry FIFO, delivered in order.
  - dout_valid = FIFO not empty; dout = head entry.
  - A pop happens when dout_valid && dout_ready.
  - Push when not full: accepted.
  - Push when full with a pop in the same cycle: accepted, occupancy stays 2.
  - Push when full without a pop: the new sample is discarded, drop_flag is set, and the FIFO is unchanged.
- flag_clr clears both flags. If a flag-setting event happens in the same cycle, set wins.
- Reset values: dout = 0, dout_valid = 0, sat_flag = 0, drop_flag = 0, FIFO empty, state FLUSH.
- Reset mid-operation discards FIFO contents and restarts the flush.

## Timing
- A kept sample arriving at edge t (din_valid high) is visible at dout with dout_valid = 1 after edge t+1 if the FIFO was empty. Latency is 1 cycle.
- A sample popped at edge t is replaced by the next entry, or dout_valid falls, after that same edge.
- With dout_ready held high, the output rate is 1 sample per M valid inputs, and the FIFO never exceeds 1 entry.
- Flags update on the same edge as the triggering push.

## Configuration
- Macro: HDEC_ROUND_SAT_EN.
- Defined: round-half-up plus saturation as above; sat_flag is live.
- Undefined: plain truncation, dout = din[SHIFT+DOUT_W-1:SHIFT]. Out-of-range values wrap, and sat_flag is tied to 0.

## Structure
- Package hdec_pkg holds:
  - the state enum {FLUSH, RUN};
  - a function computing counter widths, $clog2 of M and FLUSH_LEN+1;
  - the default constants for DIN_W/DOUT_W/SHIFT/M.
- Sub-module hdec_skid_fifo: the 2-entry FIFO with push/pop, full/empty, and the drop indication. Width is a parameter.

## Test plan
- Flush: reset, then 21 valid samples of din=1000 → dout_valid stays 0. Sample #22 (din=1000) → dout=2 one cycle later; the next dout comes on sample #27.
- DC: after flush, din=101092 every cycle, dout_ready=1 → dout=197 on every 5th valid input. dout_valid stays high for exactly one cycle per output; sat_flag stays 0.
- Rounding (macro on), one din per kept slot:
  - din=256 → 1;
  - din=255 → 0;
  - din=-256 → 0;
  - din=-257 → -1.
- Saturation: din=0x7FFFF.
  - Macro on: dout=255 and sat_flag=1.
  - Macro off: dout=-1 (0x1FF) and sat_flag=0.
  - din=0x80000 with macro on: dout=-256.
- Backpressure: dout_ready=0 across 3 kept samples A, B, C → drop_flag=1. Then dout_ready=1 → A, then B, on consecutive cycles; C never appears. flag_clr then clears drop_flag.
- Reset mid-run: assert reset while the FIFO holds 1 entry → dout_valid=0 immediately and flags are 0. After release, 21 more valid samples are discarded before any output.

Source files
------------

// File: rtl/hdec_pkg.sv
// rtl/hdec_pkg.sv - shared state type, default widths and counter-width helper for hdec_decimator
package hdec_pkg;

    localparam int DEF_DIN_W  = 20;
    localparam int DEF_DOUT_W = 9;
    localparam int DEF_SHIFT  = 9;
    localparam int DEF_M      = 5;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } hdec_state_e;

    // Width needed to hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hdec_skid_fifo.sv
// rtl/hdec_skid_fifo.sv - 2-entry in-order output buffer with push/pop, full/empty and drop indication
module hdec_skid_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_req,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         drop
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         pop;
    logic         accept;

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign pop    = !empty && pop_req;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign wr_ptr = rd_ptr ^ count[0];
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_data;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(accept) - 2'(pop);
        end
    end

endmodule

// File: rtl/hdec_decimator.sv
// rtl/hdec_decimator.sv - FIR start-up flush, decimate-by-M, rescale and buffered output
// Optional macro HDEC_ROUND_SAT_EN: round-half-up with saturation instead of plain truncation.
module hdec_decimator
    import hdec_pkg::*;
#(
    parameter int DIN_W     = DEF_DIN_W,
    parameter int DOUT_W    = DEF_DOUT_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int M         = DEF_M,
    parameter int PHASE     = 0,
    parameter int FLUSH_LEN = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DIN_W-1:0]  din,
    input  logic                     din_valid,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    input  logic                     flag_clr,
    output logic                     sat_flag,
    output logic                     drop_flag
);

    localparam int PH_W = cnt_w(M);
    localparam int FL_W = cnt_w(FLUSH_LEN + 1);

    hdec_state_e       state;
    logic [FL_W-1:0]   flush_cnt;
    logic [PH_W-1:0]   phase;
    logic              keep;
    logic [DOUT_W-1:0] scaled;
    logic              scaled_sat;
    logic              stage_valid;
    logic [DOUT_W-1:0] stage_data;
    logic              stage_sat;
    logic [DOUT_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              unused_fifo_full;

    assign keep = din_valid && (state == RUN) && (phase == PH_W'(PHASE));

`ifdef HDEC_ROUND_SAT_EN
    localparam int XW = DIN_W + 1;
    localparam logic signed [XW-1:0] HALF   = XW'(1 << (SHIFT - 1));
    localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_LO = XW'(-(1 << (DOUT_W - 1)));

    logic signed [XW-1:0] rsum;
    logic signed [XW-1:0] rshift;

    // One extra bit of headroom so the rounding offset cannot overflow.
    always_comb begin
        rsum       = {din[DIN_W-1], din} + HALF;
        rshift     = rsum >>> SHIFT;
        scaled     = rshift[DOUT_W-1:0];
        scaled_sat = 1'b0;
        if (rshift > SAT_HI) begin
            scaled     = SAT_HI[DOUT_W-1:0];
            scaled_sat = 1'b1;
        end else if (rshift < SAT_LO) begin
            scaled     = SAT_LO[DOUT_W-1:0];
            scaled_sat = 1'b1;
        end
    end
`else
    logic unused_din_bits;

    assign scaled          = din[SHIFT+DOUT_W-1:SHIFT];
    assign scaled_sat      = 1'b0;
    assign unused_din_bits = ^{din[DIN_W-1:SHIFT+DOUT_W], din[SHIFT-1:0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FLUSH;
            flush_cnt   <= '0;
            phase       <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_sat   <= 1'b0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage_data <= scaled;
                stage_sat  <= scaled_sat;
            end
            if (din_valid) begin
                case (state)
                    FLUSH: begin
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        phase <= (phase == PH_W'(M - 1)) ? '0 : phase + 1'b1;
                    end
                    default: state <= FLUSH;
                endcase
            end
        end
    end

    hdec_skid_fifo #(
        .W(DOUT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (stage_valid),
        .push_data(stage_data),
        .pop_req  (dout_ready),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (unused_fifo_full),
        .drop     (fifo_drop)
    );

    assign dout       = fifo_head;
    assign dout_valid = !fifo_empty;

    // Set takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sat_flag  <= (stage_valid && stage_sat) || (sat_flag && !flag_clr);
            drop_flag <= fifo_drop || (drop_flag && !flag_clr);
        end
    end

endmodule
